// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg: shared types and constants for the memory-port arbiter
// Revision: 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    // The counter must hold LATENCY-1; a single-cycle latency still needs one bit.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2: combinational two-way round-robin picker
// Revision: 1.0
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic grant_o,
    output logic grant_valid_o
);

    always_comb begin
        grant_o       = REQ_IFU;
        grant_valid_o = valid0_i | valid1_i;
        // On a tie the requester that did not win last time gets the port.
        if (valid0_i && valid1_i) begin
            grant_o = ~last_grant_i;
        end else if (valid1_i) begin
            grant_o = REQ_LSU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter: shares one memory port between IFU (read) and LSU (read/write)
// Revision: 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ifu_req_valid_i,
    output logic                  ifu_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr_i,
    output logic                  ifu_resp_valid_o,
    input  logic                  ifu_resp_ready_i,
    output logic [DATA_WIDTH-1:0] ifu_resp_data_o,

    input  logic                  lsu_req_valid_i,
    output logic                  lsu_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr_i,
    input  logic                  lsu_req_wen_i,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdata_i,
    input  logic [7:0]            lsu_req_mask_i,
    output logic                  lsu_resp_valid_o,
    input  logic                  lsu_resp_ready_i,
    output logic [DATA_WIDTH-1:0] lsu_resp_data_o,

    output logic [ADDR_WIDTH-1:0] mem_raddr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [7:0]            mem_mask_o,
    output logic                  mem_wen_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o
);

    localparam int               CNT_W    = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            mask_q, mask_d;
    logic                  wen_q, wen_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  grant;
    logic                  grant_valid;

    rr_arb2 u_rr_arb2 (
        .valid0_i      (ifu_req_valid_i),
        .valid1_i      (lsu_req_valid_i),
        .last_grant_i  (last_grant_q),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            wen_q        <= 1'b0;
            owner_q      <= REQ_IFU;
            last_grant_q <= REQ_IFU;
            cnt_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            wen_q        <= wen_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        mask_d           = mask_q;
        wen_d            = wen_q;
        owner_d          = owner_q;
        last_grant_d     = last_grant_q;
        cnt_d            = cnt_q;
        rdata_d          = rdata_q;
        ifu_req_ready_o  = 1'b0;
        lsu_req_ready_o  = 1'b0;
        ifu_resp_valid_o = 1'b0;
        lsu_resp_valid_o = 1'b0;
        mem_wen_o        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Ready goes only to the granted requester, so valid&&ready is implied here.
                if (grant_valid && rst_n) begin
                    ifu_req_ready_o = (grant == REQ_IFU);
                    lsu_req_ready_o = (grant == REQ_LSU);
                    owner_d         = grant;
                    last_grant_d    = grant;
                    cnt_d           = CNT_LOAD;
                    state_d         = BUSY;
                    if (grant == REQ_LSU) begin
                        addr_d  = lsu_req_addr_i;
                        wen_d   = lsu_req_wen_i;
                        wdata_d = lsu_req_wdata_i;
                        mask_d  = lsu_req_mask_i;
                    end else begin
                        addr_d  = ifu_req_addr_i;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        mask_d  = '0;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    mem_wen_o = wen_q;
                    rdata_d   = wen_q ? '0 : mem_rdata_i;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESP: begin
                ifu_resp_valid_o = (owner_q == REQ_IFU);
                lsu_resp_valid_o = (owner_q == REQ_LSU);
                if ((owner_q == REQ_IFU && ifu_resp_ready_i) ||
                    (owner_q == REQ_LSU && lsu_resp_ready_i)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_raddr_o     = addr_q;
    assign mem_waddr_o     = addr_q;
    assign mem_wdata_o     = wdata_q;
    assign mem_mask_o      = mask_q;
    assign ifu_resp_data_o = rdata_q;
    assign lsu_resp_data_o = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter: directed scoreboard bench; instance 0 LATENCY=1, instance 1 LATENCY=3
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

    typedef struct {
        int          inst;
        logic        owner;
        logic [63:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n          [2];
    logic        ifu_req_valid  [2];
    logic        ifu_req_ready  [2];
    logic [63:0] ifu_req_addr   [2];
    logic        ifu_resp_valid [2];
    logic        ifu_resp_ready [2];
    logic [63:0] ifu_resp_data  [2];
    logic        lsu_req_valid  [2];
    logic        lsu_req_ready  [2];
    logic [63:0] lsu_req_addr   [2];
    logic        lsu_req_wen    [2];
    logic [63:0] lsu_req_wdata  [2];
    logic [7:0]  lsu_req_mask   [2];
    logic        lsu_resp_valid [2];
    logic        lsu_resp_ready [2];
    logic [63:0] lsu_resp_data  [2];
    logic [63:0] mem_raddr      [2];
    logic [63:0] mem_rdata      [2];
    logic [63:0] mem_waddr      [2];
    logic [7:0]  mem_mask       [2];
    logic        mem_wen        [2];
    logic [63:0] mem_wdata      [2];

    logic [63:0] mem [2][512];
    int          wen_cnt [2];
    exp_t        sb [$];
    int          n_vec  = 0;
    int          n_fail = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(
            .ADDR_WIDTH (64),
            .DATA_WIDTH (64),
            .LATENCY    ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_n[g]),
            .ifu_req_valid_i  (ifu_req_valid[g]),
            .ifu_req_ready_o  (ifu_req_ready[g]),
            .ifu_req_addr_i   (ifu_req_addr[g]),
            .ifu_resp_valid_o (ifu_resp_valid[g]),
            .ifu_resp_ready_i (ifu_resp_ready[g]),
            .ifu_resp_data_o  (ifu_resp_data[g]),
            .lsu_req_valid_i  (lsu_req_valid[g]),
            .lsu_req_ready_o  (lsu_req_ready[g]),
            .lsu_req_addr_i   (lsu_req_addr[g]),
            .lsu_req_wen_i    (lsu_req_wen[g]),
            .lsu_req_wdata_i  (lsu_req_wdata[g]),
            .lsu_req_mask_i   (lsu_req_mask[g]),
            .lsu_resp_valid_o (lsu_resp_valid[g]),
            .lsu_resp_ready_i (lsu_resp_ready[g]),
            .lsu_resp_data_o  (lsu_resp_data[g]),
            .mem_raddr_o      (mem_raddr[g]),
            .mem_rdata_i      (mem_rdata[g]),
            .mem_waddr_o      (mem_waddr[g]),
            .mem_mask_o       (mem_mask[g]),
            .mem_wen_o        (mem_wen[g]),
            .mem_wdata_o      (mem_wdata[g])
        );
        assign mem_rdata[g] = mem[g][mem_raddr[g][11:3]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: byte-masked write commits on the rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_wen[i]) begin
                wen_cnt[i]++;
                for (int b = 0; b < 8; b++) begin
                    if (mem_mask[i][b]) mem[i][mem_waddr[i][11:3]][b*8 +: 8] = mem_wdata[i][b*8 +: 8];
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic expect_resp(input int i, input logic own, input logic [63:0] d);
        exp_t e;
        e.inst  = i;
        e.owner = own;
        e.data  = d;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input int i, input logic own, input logic [63:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected response: inst %0d owner %0d data 0x%h, expected none", i, own, d);
        end else begin
            e = sb.pop_front();
            check("resp instance", 64'(i), 64'(e.inst));
            check("resp owner", 64'(own), 64'(e.owner));
            check("resp data", d, e.data);
        end
    endtask

    // Monitor: any response handshake pops the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ifu_resp_valid[i] || lsu_resp_valid[i])
                check("resp_valid exclusive", 64'(ifu_resp_valid[i] && lsu_resp_valid[i]), 64'd0);
            if (ifu_resp_valid[i] && ifu_resp_ready[i]) pop_cmp(i, 1'b0, ifu_resp_data[i]);
            if (lsu_resp_valid[i] && lsu_resp_ready[i]) pop_cmp(i, 1'b1, lsu_resp_data[i]);
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
    task automatic issue(input int i, input logic lsu, input logic [63:0] a, input logic w,
                         input logic [63:0] d, input logic [7:0] m);
        int   k;
        logic rdy;
        if (lsu) begin
            lsu_req_valid[i] = 1'b1;
            lsu_req_addr[i]  = a;
            lsu_req_wen[i]   = w;
            lsu_req_wdata[i] = d;
            lsu_req_mask[i]  = m;
        end else begin
            ifu_req_valid[i] = 1'b1;
            ifu_req_addr[i]  = a;
        end
        k   = 0;
        rdy = 1'b0;
        while (!rdy && k < 50) begin
            @(negedge clk);
            rdy = lsu ? lsu_req_ready[i] : ifu_req_ready[i];
            k++;
        end
        if (!rdy) check("request handshake timeout", 64'(rdy), 64'd1);
        @(posedge clk);
        #1;
        if (lsu) lsu_req_valid[i] = 1'b0;
        else     ifu_req_valid[i] = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input int i);
        check("rst ifu_req_ready", 64'(ifu_req_ready[i]), 64'd0);
        check("rst lsu_req_ready", 64'(lsu_req_ready[i]), 64'd0);
        check("rst ifu_resp_valid", 64'(ifu_resp_valid[i]), 64'd0);
        check("rst lsu_resp_valid", 64'(lsu_resp_valid[i]), 64'd0);
        check("rst mem_wen", 64'(mem_wen[i]), 64'd0);
        check("rst mem_raddr", mem_raddr[i], 64'd0);
        check("rst mem_waddr", mem_waddr[i], 64'd0);
        check("rst mem_wdata", mem_wdata[i], 64'd0);
        check("rst mem_mask", 64'(mem_mask[i]), 64'd0);
        check("rst resp_data", ifu_resp_data[i] | lsu_resp_data[i], 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int cyc;
        int wen_base;
        for (int i = 0; i < 2; i++) begin
            rst_n[i]          = 1'b1;
            ifu_req_valid[i]  = 1'b0;
            ifu_req_addr[i]   = '0;
            ifu_resp_ready[i] = 1'b1;
            lsu_req_valid[i]  = 1'b0;
            lsu_req_addr[i]   = '0;
            lsu_req_wen[i]    = 1'b0;
            lsu_req_wdata[i]  = '0;
            lsu_req_mask[i]   = '0;
            lsu_resp_ready[i] = 1'b1;
            wen_cnt[i]        = 0;
            for (int j = 0; j < 512; j++) mem[i][j] = '0;
        end
        mem[0][0]     = 64'h0000_0000_0000_0413;
        mem[0][9'h40] = 64'hA5A5_5A5A_0123_4567;
        mem[1][0]     = 64'h0000_0000_0000_1234;
        mem[1][1]     = 64'hDEAD_BEEF_CAFE_F00D;
        #1;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Single IFU read at LATENCY=1: BUSY in cycle 1, response in cycle 2.
        expect_resp(0, 1'b0, 64'h413);
        issue(0, 1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'h00);
        @(negedge clk);
        check("ifu rd busy resp_valid", 64'(ifu_resp_valid[0]), 64'd0);
        check("ifu rd busy raddr", mem_raddr[0], 64'h8000_0000);
        @(negedge clk);
        check("ifu rd cycle2 resp_valid", 64'(ifu_resp_valid[0]), 64'd1);
        wait_drain();
        check("ifu rd no write", 64'(wen_cnt[0]), 64'd0);

        // LSU masked write then read back.
        expect_resp(0, 1'b1, 64'd0);
        issue(0, 1'b1, 64'h8000_0100, 1'b1, 64'h1122_3344_5566_7788, 8'h0F);
        @(negedge clk);
        check("lsu wr mem_wen", 64'(mem_wen[0]), 64'd1);
        check("lsu wr waddr", mem_waddr[0], 64'h8000_0100);
        check("lsu wr wdata", mem_wdata[0], 64'h1122_3344_5566_7788);
        check("lsu wr mask", 64'(mem_mask[0]), 64'h0F);
        @(negedge clk);
        check("lsu wr wen dropped", 64'(mem_wen[0]), 64'd0);
        check("lsu wr ack valid", 64'(lsu_resp_valid[0]), 64'd1);
        @(posedge clk);
        #1;
        expect_resp(0, 1'b1, 64'h0000_0000_5566_7788);
        issue(0, 1'b1, 64'h8000_0100, 1'b0, 64'd0, 8'h00);
        wait_drain();
        check("lsu wr single pulse", 64'(wen_cnt[0]), 64'd1);
        check("lsu wr memory", mem[0][9'h20], 64'h0000_0000_5566_7788);

        // Both valid from reset: LSU, IFU, LSU, IFU.
        rst_n[0]         = 1'b0;
        ifu_req_valid[0] = 1'b1;
        ifu_req_addr[0]  = 64'h8000_0000;
        lsu_req_valid[0] = 1'b1;
        lsu_req_addr[0]  = 64'h8000_0200;
        lsu_req_wen[0]   = 1'b0;
        lsu_req_mask[0]  = 8'h00;
        expect_resp(0, 1'b1, 64'hA5A5_5A5A_0123_4567);
        expect_resp(0, 1'b0, 64'h413);
        expect_resp(0, 1'b1, 64'hA5A5_5A5A_0123_4567);
        expect_resp(0, 1'b0, 64'h413);
        @(negedge clk);
        check("ready gated in reset", {62'd0, ifu_req_ready[0], lsu_req_ready[0]}, 64'd0);
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        grants   = 0;
        cyc      = 0;
        while (grants < 4 && cyc < 60) begin
            @(negedge clk);
            if (ifu_req_ready[0] || lsu_req_ready[0]) begin
                check("rr grant", {62'd0, ifu_req_ready[0], lsu_req_ready[0]},
                      (grants % 2 == 0) ? 64'b01 : 64'b10);
                grants++;
            end
            cyc++;
        end
        check("rr grant count", 64'(grants), 64'd4);
        @(posedge clk);
        #1;
        ifu_req_valid[0] = 1'b0;
        lsu_req_valid[0] = 1'b0;
        wait_drain();

        // LATENCY=3 with IFU back-pressure; LSU waits for the IFU handshake.
        ifu_resp_ready[1] = 1'b0;
        expect_resp(1, 1'b0, 64'hDEAD_BEEF_CAFE_F00D);
        expect_resp(1, 1'b1, 64'h1234);
        issue(1, 1'b0, 64'h8000_0008, 1'b0, 64'd0, 8'h00);
        lsu_req_valid[1] = 1'b1;
        lsu_req_addr[1]  = 64'h8000_0000;
        lsu_req_wen[1]   = 1'b0;
        lsu_req_mask[1]  = 8'h00;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("L3 busy resp_valid", 64'(ifu_resp_valid[1]), 64'd0);
            check("L3 busy lsu ready", 64'(lsu_req_ready[1]), 64'd0);
        end
        for (int k = 4; k <= 8; k++) begin
            @(negedge clk);
            check("L3 held resp_valid", 64'(ifu_resp_valid[1]), 64'd1);
            check("L3 held resp_data", ifu_resp_data[1], 64'hDEAD_BEEF_CAFE_F00D);
            check("L3 held lsu ready", 64'(lsu_req_ready[1]), 64'd0);
        end
        @(posedge clk);
        #1;
        ifu_resp_ready[1] = 1'b1;
        @(negedge clk);
        check("L3 handshake-cycle lsu ready", 64'(lsu_req_ready[1]), 64'd0);
        @(negedge clk);
        check("L3 lsu ready after handshake", 64'(lsu_req_ready[1]), 64'd1);
        @(posedge clk);
        #1;
        lsu_req_valid[1] = 1'b0;
        wait_drain();

        // Reset in the 2nd BUSY cycle of an LSU write drops the write.
        wen_base = wen_cnt[1];
        issue(1, 1'b1, 64'h8000_0300, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        @(posedge clk);
        #2;
        rst_n[1] = 1'b0;
        #1;
        check_reset_outputs(1);
        repeat (3) @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        repeat (6) @(negedge clk);
        check("reset-dropped write count", 64'(wen_cnt[1]), 64'(wen_base));
        check("reset-dropped write memory", mem[1][9'h60], 64'd0);
        check("reset no late response", 64'(lsu_resp_valid[1]), 64'd0);
        check("scoreboard empty at end", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
